// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, the IR capture pattern
// and the TAP next-state function used by the FSM.
package jtag_pkg;

    // Encoding matches the IEEE 1149.1 reference diagram so tap_state can be
    // read directly against a standard JTAG debugger trace.
    typedef enum logic [3:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_e;

    // Low two bits loaded into the IR shift register in Capture-IR; the
    // remaining upper bits are zero-extended by the user of this constant.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    localparam int IDCODE_W = 32;

    // One step of the 16-state TAP diagram for a given TMS sample.
    function automatic tap_state_e tap_next_state(input tap_state_e cur, input logic tms);
        tap_state_e nxt;
        case (cur)
            TAP_TLR:     nxt = tms ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     nxt = tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   nxt = tms ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   nxt = tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    nxt = tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   nxt = tms ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: nxt = tms ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   nxt = tms ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   nxt = tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   nxt = tms ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   nxt = tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    nxt = tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   nxt = tms ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: nxt = tms ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   nxt = tms ? TAP_UPDIR   : TAP_SHIR;
            TAP_UPDIR:   nxt = tms ? TAP_SELDR   : TAP_RTI;
            default:     nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine: state register plus next-state decode only.
// The next state is exported so the datapath can act on entry to TLR.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_e state,
    output tap_state_e next_state,
    output logic       tlr
);

    tap_state_e state_r;
    tap_state_e next_state_s;
    logic       tlr_r;

    assign next_state_s = tap_next_state(state_r, TMS);

    // Advance the TAP one state per rising TCLK; tlr is registered alongside.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            state_r <= TAP_TLR;
            tlr_r   <= 1'b1;
        end else begin
            state_r <= next_state_s;
            tlr_r   <= (next_state_s == TAP_TLR);
        end
    end

    assign state      = state_r;
    assign next_state = next_state_s;
    assign tlr        = tlr_r;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: instruction register, opcode decode, IDCODE and
// bypass data registers, external chain select and falling-edge TDO retiming.
// Every register action belongs to the state being left on that rising edge.
module jtag_tap_param
    import jtag_pkg::*;
#(
    parameter int                IR_W       = 4,
    parameter int                N_CHAINS   = 2,
    parameter logic [31:0]       IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_W-1:0]   IDCODE_OP  = {{(IR_W-1){1'b1}}, 1'b0}
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_en,
    input  logic [N_CHAINS-1:0] chain_tdo,
    output logic [N_CHAINS-1:0] chain_sel,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic [IR_W-1:0]     ir_q,
    output logic [3:0]          tap_state,
    output logic                tlr
);

    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);

    tap_state_e             state_s;
    tap_state_e             next_state_s;
    logic                   tlr_s;

    logic [IR_W-1:0]        ir_shift_r;
    logic [IR_W-1:0]        ir_r;
    logic [N_CHAINS-1:0]    chain_sel_r;
    logic [IDCODE_W-1:0]    idcode_shift_r;
    logic                   bypass_r;
    logic                   tdo_r;
    logic                   tdo_en_r;

    logic                   sel_chain_s;
    logic                   sel_idcode_s;
    logic                   sel_bypass_s;
    logic                   tdo_next_s;
    logic                   tdo_en_next_s;

    // One-hot chain select for an opcode; zero for IDCODE, bypass and any
    // other opcode at or above N_CHAINS.
    function automatic logic [N_CHAINS-1:0] decode_chain(input logic [IR_W-1:0] op);
        logic [N_CHAINS-1:0] sel;
        sel = {N_CHAINS{1'b0}};
        for (int i = 0; i < N_CHAINS; i++) begin
            sel[i] = (op == IR_W'(i));
        end
        return sel;
    endfunction

    jtag_tap_fsm u_fsm (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state_s),
        .next_state (next_state_s),
        .tlr        (tlr_s)
    );

    // Chain select is kept in step with ir_r, so decode here is a plain view.
    assign sel_chain_s  = |chain_sel_r;
    assign sel_idcode_s = (ir_r == IDCODE_OP) & ~sel_chain_s;
    assign sel_bypass_s = ~sel_chain_s & ~sel_idcode_s;

    // Instruction register: capture, shift and update, with IDCODE forced
    // from the edge that enters TLR onwards so ir_q already reads IDCODE_OP
    // in the first TLR cycle. Update-IR can never precede TLR directly.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            ir_shift_r  <= {IR_W{1'b0}};
            ir_r        <= IDCODE_OP;
            chain_sel_r <= {N_CHAINS{1'b0}};
        end else if ((state_s == TAP_TLR) || (next_state_s == TAP_TLR)) begin
            ir_r        <= IDCODE_OP;
            chain_sel_r <= decode_chain(IDCODE_OP);
        end else begin
            case (state_s)
                TAP_CAPIR: ir_shift_r <= IR_CAPTURE;
                TAP_SHIR:  ir_shift_r <= {TDI, ir_shift_r[IR_W-1:1]};
                TAP_UPDIR: begin
                    ir_r        <= ir_shift_r;
                    chain_sel_r <= decode_chain(ir_shift_r);
                end
                default: begin
                    ir_shift_r <= ir_shift_r;
                end
            endcase
        end
    end

    // IDCODE and bypass data registers; only the selected one captures/shifts.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            idcode_shift_r <= {IDCODE_W{1'b0}};
            bypass_r       <= 1'b0;
        end else begin
            case (state_s)
                TAP_CAPDR: begin
                    if (sel_idcode_s) begin
                        idcode_shift_r <= IDCODE_VAL;
                    end
                    if (sel_bypass_s) begin
                        bypass_r <= 1'b0;
                    end
                end
                TAP_SHDR: begin
                    if (sel_idcode_s) begin
                        idcode_shift_r <= {TDI, idcode_shift_r[IDCODE_W-1:1]};
                    end
                    if (sel_bypass_s) begin
                        bypass_r <= TDI;
                    end
                end
                default: begin
                    bypass_r <= bypass_r;
                end
            endcase
        end
    end

    // Select the serial bit presented on TDO for the current shift state.
    always_comb begin
        tdo_next_s    = 1'b0;
        tdo_en_next_s = 1'b0;
        case (state_s)
            TAP_SHIR: begin
                tdo_next_s    = ir_shift_r[0];
                tdo_en_next_s = 1'b1;
            end
            TAP_SHDR: begin
                tdo_en_next_s = 1'b1;
                if (sel_chain_s) begin
                    tdo_next_s = |(chain_tdo & chain_sel_r);
                end else if (sel_idcode_s) begin
                    tdo_next_s = idcode_shift_r[0];
                end else begin
                    tdo_next_s = bypass_r;
                end
            end
            default: begin
                tdo_next_s    = 1'b0;
                tdo_en_next_s = 1'b0;
            end
        endcase
    end

    // Retime TDO and its pad enable on the falling edge of TCLK.
    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) begin
            tdo_r    <= 1'b0;
            tdo_en_r <= 1'b0;
        end else begin
            tdo_r    <= tdo_next_s;
            tdo_en_r <= tdo_en_next_s;
        end
    end

    // DR strobes are pure state decodes; the chain wrapper qualifies them.
    assign capture_dr = (state_s == TAP_CAPDR);
    assign shift_dr   = (state_s == TAP_SHDR);
    assign update_dr  = (state_s == TAP_UPDDR);

    assign TDO       = tdo_r;
    assign TDO_en    = tdo_en_r;
    assign chain_sel = chain_sel_r;
    assign ir_q      = ir_r;
    assign tap_state = state_s;
    assign tlr       = tlr_s;

endmodule

// File: doc/jtag_tap_param.md
# jtag_tap_param

Parametrised IEEE 1149.1 test access port for the next generation of JTAG wrappers. It contains the full 16-state TAP FSM, an IR of configurable width, bypass and IDCODE registers, and a one-hot selector over `N_CHAINS` external data registers (boundary scan, internal scan and similar). It sits between the chip-level JTAG pins and the per-design scan chains, replacing hand-wired per-design TAP/IR/decode/mux glue.

## Interface
Parameters:
- `IR_W`, default 4: instruction register width; must be ≥ 2.
- `N_CHAINS`, default 2: number of external data registers; must satisfy 1 ≤ `N_CHAINS` ≤ 2^`IR_W` − 2.
- `IDCODE_VAL`, default 32'h1000_0001: device ID; bit 0 must be 1.
- `IDCODE_OP`, default 2^`IR_W` − 2: opcode selecting IDCODE.

Ports (all signals are synchronous to `TCLK`; reset is asynchronous and active-low on `TRST`):
- `TCLK` in 1: test clock, the only clock.
- `TRST` in 1: asynchronous active-low reset.
- `TMS` in 1: test mode select.
- `TDI` in 1: test data in.
- `TDO` out 1: test data out, updated on falling `TCLK`.
- `TDO_en` out 1: output enable for the `TDO` pad.
- `chain_tdo` in `N_CHAINS`: serial outputs of the external chains.
- `chain_sel` out `N_CHAINS`: one-hot selected chain, decoded from the IR.
- `capture_dr`, `shift_dr`, `update_dr` out 1 each: DR strobes, already ANDed with `chain_sel` inside the chain wrapper, not here.
- `ir_q` out `IR_W`: current instruction.
- `tap_state` out 4: FSM state encoding.
- `tlr` out 1: high while in Test-Logic-Reset.

## Operation
- **FSM**: the standard 16-state TAP diagram. `TMS` is sampled on rising `TCLK`. Five consecutive `TMS`=1 cycles reach Test-Logic-Reset (TLR) from any state.
- **Edge rule**: every register action for a state happens on the rising edge that leaves that state.
- **IR path**:
  - Capture-IR loads the shift register with `{0…0,01}`.
  - Shift-IR shifts right, taking `TDI` into the MSB; the LSB goes to `TDO`.
  - Update-IR copies the shift register into `ir_q`.
  - While in TLR, `ir_q` is forced to `IDCODE_OP` synchronously.
- **Decode**:
  - `ir_q` < `N_CHAINS` → `chain_sel` bit `ir_q` is set.
  - `ir_q` == `IDCODE_OP` → IDCODE register.
  - All other values, including all-ones → bypass.
  - `chain_sel` is 0 unless a chain is selected.
- **IDCODE**: Capture-DR loads `IDCODE_VAL`; Shift-DR shifts right, with `TDI` entering at bit 31.
- **Bypass**: Capture-DR loads 0; Shift-DR loads `TDI`.
- **Strobes**:
  - `capture_dr` is high in Capture-DR.
  - `shift_dr` is high in Shift-DR.
  - `update_dr` is high in Update-DR.
  - All three are combinational decodes of the state.
- **TDO mux**:
  - Shift-IR → IR LSB.
  - Shift-DR → LSB of the selected register (`chain_tdo[ir_q]`, IDCODE LSB or bypass bit).
  - `TDO` and `TDO_en` are registered on the falling edge.
  - `TDO_en` = 1 only in Shift-IR or Shift-DR; otherwise `TDO_en` = 0 and `TDO` = 0.
- **TRST low**, asynchronously:
  - state = TLR, `ir_q` = `IDCODE_OP`, IR shift register = 0, IDCODE shift register = 0, bypass = 0.
  - `TDO` = 0, `TDO_en` = 0, `tlr` = 1.
  - `chain_sel` = 0, because `IDCODE_OP` is not a chain opcode.
  - This applies mid-shift; a partial shift is discarded and `ir_q` is not updated.

## Timing
- **Reset values**: all outputs as listed under TRST; `tap_state` = 4'hF in TLR.
- **State change**: one `TCLK` per transition.
- **`TDO` latency**: the register LSB appears on `TDO` half a cycle after entering a Shift state, then advances one bit per cycle.
- **Shift length**: a shift of length L passes through the register on the L rising edges that leave Shift-*.
- **IR length**:
  - IDCODE: a 32-bit shift returns `IDCODE_VAL`, LSB first.
  - Bypass: `TDI` → `TDO` delay is exactly one `TCLK`.
- **Simultaneous events**:
  - TRST release coincident with a `TCLK` edge: stays in TLR for that edge.
  - Update-IR and TLR never coincide; the FSM guarantees it.

## Structure
- Package `jtag_pkg`: 4-bit state enum using the IEEE encoding (TLR = F, RTI = C, SelDR = 7, CapDR = 6, ShDR = 2, Ex1DR = 1, PauseDR = 3, Ex2DR = 0, UpdDR = 5, SelIR = 4, CapIR = E, ShIR = A, Ex1IR = 9, PauseIR = B, Ex2IR = 8, UpdIR = D), plus the IR capture constant.
- Sub-module `jtag_tap_fsm`: the state register and next-state logic only.
- The top level holds the IR, decode, IDCODE, bypass and `TDO` retiming.

## Test plan
- Pulse `TRST` low with `TMS` = 0 → `tap_state` = F, `ir_q` = `IDCODE_OP` (4'hE), `TDO_en` = 0, `chain_sel` = 2'b00.
- From Pause-DR, drive five `TMS` = 1 edges → `tlr` = 1 on the fifth, `ir_q` = 4'hE.
- After reset, go TLR → RTI → Shift-DR and shift 32 bits → `TDO` yields 32'h1000_0001 LSB first, `TDO_en` = 1 throughout.
- Shift-IR with `TDI` = 1111 → captured bits read 1,0,0,0. After Update-IR, `ir_q` = 4'hF (bypass); a DR shift of 1,0,1,1 returns 0,1,0,1,1, with one cycle of delay.
- Load IR = 4'h1 → `chain_sel` = 2'b10. Through a DR scan, `capture_dr`, `shift_dr` and `update_dr` pulse once per visit, and `TDO` follows `chain_tdo[1]`.
- Assert `TRST` during Shift-IR after 2 of 4 bits → `ir_q` = 4'hE (not the partial value), `TDO` = 0 immediately.
